// File: rtl/sanity_pkg.sv
// Shared types for the sanity PC monitor: FSM states and failure causes.
package sanity_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      MISALIGN = 2'd1,
      RANGE    = 2'd2,
      TIMEOUT  = 2'd3
   } fail_code_t;

   localparam int unsigned HIST_DEPTH = 4;

endpackage

// File: rtl/sanity_watchdog.sv
// Counts consecutive ungranted RUN cycles; expired fires on the TIMEOUT-th one
// unless the same cycle also clears it.
module sanity_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   assign expired = tick && !clear && (count == W'(TIMEOUT - 1));

   // Clear wins over tick; the count parks at TIMEOUT instead of wrapping
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         count <= '0;
      end else if (tick && (count != W'(TIMEOUT))) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sanity_pc_monitor.sv
// Watches core instruction fetches and reports pass/fail of a sanity test.
// Optional history of the last four granted addresses: SANITY_PC_MON_HISTORY_EN.
module sanity_pc_monitor #(
   parameter int unsigned NUM_WORDS = 256,
   parameter logic [31:0] BOOT_ADDR = 32'h0,
   parameter logic [31:0] END_ADDR  = 32'h0000_00FC,
   parameter int unsigned END_HITS  = 2,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         fetch_enable_i,
   input  logic         instr_req_i,
   input  logic         instr_gnt_i,
   input  logic [31:0]  instr_addr_i,
   output logic         done_o,
   output logic         fail_o,
   output logic [1:0]   fail_code_o,
   output logic [31:0]  fetch_count_o,
   output logic [31:0]  fail_addr_o,
   output logic [127:0] history_o
);

   import sanity_pkg::*;

   localparam int unsigned HIT_W = $clog2(END_HITS + 1);
   localparam logic [32:0] LIMIT = {1'b0, BOOT_ADDR} + 33'(NUM_WORDS) * 33'd4;

   state_t           state;
   fail_code_t       fail_code_q;
   logic [HIT_W-1:0] end_hits;
   logic [31:0]      last_addr;
   logic             fetch;
   logic             misaligned;
   logic             out_of_range;
   logic             end_final;
   logic             wd_clear;
   logic             wd_tick;
   logic             wd_expired;

   assign fetch        = (state == RUN) && instr_req_i && instr_gnt_i;
   assign misaligned   = (instr_addr_i[1:0] != 2'b00);
   assign out_of_range = ({1'b0, instr_addr_i} < {1'b0, BOOT_ADDR}) ||
                         ({1'b0, instr_addr_i} >= LIMIT);
   assign end_final    = (instr_addr_i == END_ADDR) &&
                         (end_hits == HIT_W'(END_HITS - 1));
   assign wd_clear     = fetch || ((state == IDLE) && fetch_enable_i);
   assign wd_tick      = (state == RUN) && !fetch;
   assign fail_code_o  = fail_code_q;

   sanity_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (wd_clear),
      .tick    (wd_tick),
      .expired (wd_expired)
   );

   // Failure causes are checked in priority order ahead of completion
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         fail_code_q   <= NONE;
         done_o        <= 1'b0;
         fail_o        <= 1'b0;
         fetch_count_o <= '0;
         fail_addr_o   <= '0;
         end_hits      <= '0;
         last_addr     <= '0;
      end else begin
         if (fetch) begin
            if (fetch_count_o != '1) begin
               fetch_count_o <= fetch_count_o + 32'd1;
            end
            last_addr <= instr_addr_i;
            if ((instr_addr_i == END_ADDR) && (end_hits != '1)) begin
               end_hits <= end_hits + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (fetch_enable_i) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (fetch && misaligned) begin
                  state       <= FAIL;
                  fail_o      <= 1'b1;
                  fail_code_q <= MISALIGN;
                  fail_addr_o <= instr_addr_i;
               end else if (fetch && out_of_range) begin
                  state       <= FAIL;
                  fail_o      <= 1'b1;
                  fail_code_q <= RANGE;
                  fail_addr_o <= instr_addr_i;
               end else if (wd_expired) begin
                  state       <= FAIL;
                  fail_o      <= 1'b1;
                  fail_code_q <= sanity_pkg::TIMEOUT;
                  fail_addr_o <= last_addr;
               end else if (fetch && end_final) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end else if (!fetch_enable_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

`ifdef SANITY_PC_MON_HISTORY_EN
   logic [127:0] history_q;

   // Newest address enters at [31:0]; fetches only happen in RUN, so it freezes in DONE/FAIL
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         history_q <= '0;
      end else if (fetch) begin
         history_q <= {history_q[95:0], instr_addr_i};
      end
   end

   assign history_o = history_q;
`else
   assign history_o = '0;
`endif

endmodule
